// File: rtl/secp256k1_pkg.sv
// Shared constants and types for the secp256k1 field arithmetic blocks.
package secp256k1_pkg;

  localparam logic [255:0] SECP_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  // (x + p) >> 1 for odd x equals (x >> 1) + (p >> 1) + 1, which never exceeds 256 bits.
  localparam logic [255:0] SECP_P_HALF_UP = (SECP_P >> 1) + 256'd1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_FIN_U,
    OP_FIN_V,
    OP_HALF_U,
    OP_HALF_V,
    OP_SUB_U,
    OP_SUB_V
  } run_op_t;

endpackage

// File: rtl/mod_inv_seq_if.sv
// Start/done request bus of the sequential modular inverter.
interface mod_inv_seq_if;
  logic         start;
  logic [255:0] a;
  logic         busy;
  logic         done;
  logic [255:0] inverse;
  logic         err;

  modport master (output start, a, input busy, done, inverse, err);
  modport slave  (input start, a, output busy, done, inverse, err);
endinterface

// File: rtl/mod_half_p.sv
// Combinational x/2 mod p for x < p: odd values get p added before the shift.
module mod_half_p
  import secp256k1_pkg::*;
(
  input  logic [255:0] i_x,
  output logic [255:0] o_y
);
  assign o_y = {1'b0, i_x[255:1]} + (i_x[0] ? SECP_P_HALF_UP : 256'd0);
endmodule

// File: rtl/mod_sub.sv
// Combinational (a - b) mod p for a, b < p.
module mod_sub
  import secp256k1_pkg::*;
(
  input  logic [255:0] i_a,
  input  logic [255:0] i_b,
  output logic [255:0] o_d
);
  logic [256:0] w_diff;

  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign o_d    = w_diff[256] ? (w_diff[255:0] + SECP_P) : w_diff[255:0];
endmodule

// File: rtl/mod_inv_seq.sv
// Multi-cycle a^-1 mod p (secp256k1) by binary extended Euclid, one step per clock.
module mod_inv_seq
  import secp256k1_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mod_inv_seq_if.slave bus
);
  state_t       r_state, w_state_nxt;
  run_op_t      w_op;
  logic [255:0] r_u, r_v, r_x1, r_x2, r_inv;
  logic         r_busy, r_done, r_err;
  logic         w_busy_nxt, w_done_nxt;

  logic [255:0] w_cmp_b, w_max, w_min, w_diff, w_u_red;
  logic [255:0] w_x1_half, w_x2_half, w_msub_a, w_msub_b, w_msub;
  logic         w_ge, w_u_zero, w_fin;

  // One comparator/subtractor: u vs p while loading, u vs v while running.
  assign w_cmp_b  = (r_state == LOAD) ? SECP_P : r_v;
  assign w_ge     = (r_u >= w_cmp_b);
  assign w_max    = w_ge ? r_u : w_cmp_b;
  assign w_min    = w_ge ? w_cmp_b : r_u;
  assign w_diff   = w_max - w_min;
  assign w_u_red  = w_ge ? w_diff : r_u;
  assign w_u_zero = (w_u_red == 256'd0);
  assign w_fin    = (r_u == 256'd1) || (r_v == 256'd1);

  // The same u>=v decision picks which coefficient difference is needed.
  assign w_msub_a = w_ge ? r_x1 : r_x2;
  assign w_msub_b = w_ge ? r_x2 : r_x1;

  mod_half_p u_half_x1 (.i_x(r_x1), .o_y(w_x1_half));
  mod_half_p u_half_x2 (.i_x(r_x2), .o_y(w_x2_half));
  mod_sub    u_msub    (.i_a(w_msub_a), .i_b(w_msub_b), .o_d(w_msub));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = w_u_zero ? DONE : RUN;
      RUN:     if (w_fin) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_op       = OP_NONE;
    w_busy_nxt = (w_state_nxt == LOAD) || (w_state_nxt == RUN);
    w_done_nxt = (w_state_nxt == DONE);
    if (r_state == RUN) begin
      if (r_u == 256'd1)      w_op = OP_FIN_U;
      else if (r_v == 256'd1) w_op = OP_FIN_V;
      else if (!r_u[0])       w_op = OP_HALF_U;
      else if (!r_v[0])       w_op = OP_HALF_V;
      else if (w_ge)          w_op = OP_SUB_U;
      else                    w_op = OP_SUB_V;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_u    <= '0;
      r_v    <= '0;
      r_x1   <= '0;
      r_x2   <= '0;
      r_inv  <= '0;
      r_err  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_u   <= bus.a;
            r_v   <= SECP_P;
            r_x1  <= 256'd1;
            r_x2  <= 256'd0;
            r_inv <= '0;
            r_err <= 1'b0;
          end
        end
        LOAD: begin
          r_u <= w_u_red;
          if (w_u_zero) begin
            r_err <= 1'b1;
            r_inv <= '0;
          end
        end
        RUN: begin
          unique case (w_op)
            OP_FIN_U:  r_inv <= r_x1;
            OP_FIN_V:  r_inv <= r_x2;
            OP_HALF_U: begin r_u <= r_u >> 1; r_x1 <= w_x1_half; end
            OP_HALF_V: begin r_v <= r_v >> 1; r_x2 <= w_x2_half; end
            OP_SUB_U:  begin r_u <= w_diff;   r_x1 <= w_msub;    end
            OP_SUB_V:  begin r_v <= w_diff;   r_x2 <= w_msub;    end
            default:   ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.inverse = r_inv;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_mod_inv_seq.sv
// Randomized bench for mod_inv_seq against a Fermat-exponentiation reference.
module tb_mod_inv_seq;
  import secp256k1_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod_inv_seq_if bus();
  mod_inv_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [255:0] INV2 =
    256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] t;
    logic [511:0] m;
    t = {256'd0, x} * {256'd0, y};
    m = t % {256'd0, SECP_P};
    return m[255:0];
  endfunction

  // Reference: a^(p-2) mod p by square-and-multiply; 0 maps to 0.
  function automatic logic [255:0] ref_inv(input logic [255:0] x);
    logic [255:0] xr, e, r, b;
    xr = (x >= SECP_P) ? x - SECP_P : x;
    if (xr == 256'd0) return 256'd0;
    e = SECP_P - 256'd2;
    r = 256'd1;
    b = xr;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mulmod(r, b);
      b = mulmod(b, b);
    end
    return r;
  endfunction

  function automatic logic ref_err(input logic [255:0] x);
    return (x == 256'd0) || (x == SECP_P);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  // lat = k means done was seen in cycle N+k, where N is the accepting edge.
  task automatic run_op(input logic [255:0] av, input bit pulse_run,
                        output logic [255:0] inv, output logic e,
                        output int lat, output logic [3:0] bpat);
    @(negedge clk);
    chk("idle_done_low", 256'(bus.done), 256'd0);
    bus.start = 1'b1;
    bus.a     = av;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat  = 0;
    bpat = '0;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      if (k < 4) bpat[k] = bus.busy;
      if (pulse_run && k == 4) begin bus.start = 1'b1; bus.a = ~av; end
      if (pulse_run && k == 5) bus.start = 1'b0;
      if (bus.done) begin lat = k; break; end
    end
    bus.start = 1'b0;
    inv = bus.inverse;
    e   = bus.err;
    if (lat == 0) chk("timeout", 256'd0, 256'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] dir_a   [6];
    logic [255:0] dir_inv [6];
    logic         dir_err [6];
    logic [255:0] av, inv, held;
    logic         e, seen;
    int           lat;
    logic [3:0]   bpat;

    bus.start = 1'b0;
    bus.a     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 256'(bus.busy), 256'd0);
    chk("rst_done", 256'(bus.done), 256'd0);
    chk("rst_inv", bus.inverse, 256'd0);
    chk("rst_err", 256'(bus.err), 256'd0);
    rst_n = 1'b1;

    dir_a[0] = 256'd1;           dir_inv[0] = 256'd1;               dir_err[0] = 1'b0;
    dir_a[1] = 256'd2;           dir_inv[1] = INV2;                 dir_err[1] = 1'b0;
    dir_a[2] = SECP_P - 256'd1;  dir_inv[2] = SECP_P - 256'd1;      dir_err[2] = 1'b0;
    dir_a[3] = SECP_P + 256'd1;  dir_inv[3] = 256'd1;               dir_err[3] = 1'b0;
    dir_a[4] = 256'd0;           dir_inv[4] = 256'd0;               dir_err[4] = 1'b1;
    dir_a[5] = SECP_P;           dir_inv[5] = 256'd0;               dir_err[5] = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(dir_a[i], 1'b0, inv, e, lat, bpat);
      chk($sformatf("dir%0d_inv", i), inv, dir_inv[i]);
      chk($sformatf("dir%0d_err", i), 256'(e), 256'(dir_err[i]));
      if (i == 0) begin
        chk("a1_latency", 256'(lat), 256'd3);
        chk("a1_busy_pattern", 256'(bpat), 256'(4'b0110));
      end
      if (dir_err[i]) chk($sformatf("dir%0d_err_latency", i), 256'(lat), 256'd2);
    end

    // start during DONE must be ignored; result stays held
    held = inv;
    run_op(256'd7, 1'b0, inv, e, lat, bpat);
    chk("a7_inv", inv, ref_inv(256'd7));
    held = inv;
    bus.start = 1'b1;
    bus.a     = 256'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("done_start_busy", 256'(bus.busy), 256'd0);
    end
    chk("done_start_held", bus.inverse, held);

    for (int i = 0; i < 36; i++) begin
      av = rand256();
      if (i % 9 == 3) av = SECP_P + 256'($urandom_range(2, 1000));
      run_op(av, (i % 4 == 1), inv, e, lat, bpat);
      chk($sformatf("rnd%0d_inv", i), inv, ref_inv(av));
      chk($sformatf("rnd%0d_err", i), 256'(e), 256'(ref_err(av)));
      chk($sformatf("rnd%0d_lat", i), 256'(lat >= 1 && lat <= 1025), 256'd1);
    end

    // reset mid-RUN abandons the operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = rand256();
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", 256'(bus.busy), 256'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 256'(bus.busy), 256'd0);
    chk("midrst_done", 256'(bus.done), 256'd0);
    chk("midrst_inv", bus.inverse, 256'd0);
    chk("midrst_err", 256'(bus.err), 256'd0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("midrst_no_activity", 256'(seen), 256'd0);

    av = rand256();
    run_op(av, 1'b0, inv, e, lat, bpat);
    chk("post_rst_inv", inv, ref_inv(av));
    av = 256'd3;
    run_op(av, 1'b0, inv, e, lat, bpat);
    chk("b2b_inv", inv, ref_inv(av));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
